// File: rtl/lcd_timed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_timed_ctrl
// Brief    : Avalon-MM slave for an HD44780-class character LCD. Each access
//            is stretched with waitrequest through setup / enable / hold /
//            recovery phases. Supports 8-bit and 4-bit (two-nibble) buses.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timed_ctrl #(
  parameter int BUS_MODE    = 8,   // 8 or 4 (4 uses LCD_data[7:4])
  parameter int SETUP_CYC   = 3,   // RS/RW/data valid before E rises
  parameter int PULSE_CYC   = 25,  // E high time
  parameter int HOLD_CYC    = 2,   // RS/RW/data held after E falls
  parameter int RECOVER_CYC = 25   // idle after hold before next E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  // One shared down-counter times every phase; size it for the longest one.
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HR  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int MAX_CYC = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SETUP   = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] C_PULSE   = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] C_HOLD    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] C_RECOVER = CNT_W'(RECOVER_CYC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic       r_op_rd;     // latched operation: 1 = read
  logic [7:0] r_wdata;     // latched write byte
  logic [7:0] r_rd_buf;    // bytes/nibbles sampled from the LCD
  logic       r_nibble;    // 0 = first (high) nibble, 1 = second
  logic       r_data_oe;   // drive LCD_data

  logic w_req;
  logic w_cnt_last;
  logic w_start;
  logic w_sample;
  logic w_renib;
  logic w_done_entry;
  logic w_op_rd;

  assign w_req        = read | write;
  assign w_cnt_last   = (r_cnt == C_ONE);
  assign w_start      = (r_state == IDLE) && w_req;
  assign w_sample     = (r_state == PULSE) && w_cnt_last;
  assign w_renib      = (r_state == RECOVER) && w_cnt_last && (BUS_MODE == 4) && !r_nibble;
  assign w_done_entry = (r_state == RECOVER) && w_cnt_last && !w_renib;
  // Read wins when both strobes are present at the start of an access.
  assign w_op_rd      = w_start ? read : r_op_rd;

  // The stall is released for exactly the DONE cycle.
  assign waitrequest  = w_req & (r_state != DONE);

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: each phase is loaded on entry and left when the count hits 1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = SETUP;
          w_cnt_next   = C_SETUP;
        end
      end
      SETUP: begin
        if (w_cnt_last) begin
          w_state_next = PULSE;
          w_cnt_next   = C_PULSE;
        end else begin
          w_cnt_next   = r_cnt - C_ONE;
        end
      end
      PULSE: begin
        if (w_cnt_last) begin
          w_state_next = HOLD;
          w_cnt_next   = C_HOLD;
        end else begin
          w_cnt_next   = r_cnt - C_ONE;
        end
      end
      HOLD: begin
        if (w_cnt_last) begin
          w_state_next = RECOVER;
          w_cnt_next   = C_RECOVER;
        end else begin
          w_cnt_next   = r_cnt - C_ONE;
        end
      end
      RECOVER: begin
        if (w_cnt_last) begin
          if (w_renib) begin
            w_state_next = SETUP;
            w_cnt_next   = C_SETUP;
          end else begin
            w_state_next = DONE;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next   = r_cnt - C_ONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Datapath and pin registers; pins are computed from the next state so
  // they line up exactly with the phase they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_rd   <= 1'b0;
      r_wdata   <= 8'h00;
      r_rd_buf  <= 8'h00;
      r_nibble  <= 1'b0;
      r_data_oe <= 1'b0;
      readdata  <= 8'h00;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_RW    <= 1'b0;
    end else begin
      if (w_start) begin
        r_op_rd <= read;
        r_wdata <= writedata;
        LCD_RS  <= address[1];
        LCD_RW  <= address[0];
      end

      LCD_E     <= (w_state_next == PULSE);
      r_data_oe <= !w_op_rd && ((w_state_next == SETUP) ||
                                (w_state_next == PULSE) ||
                                (w_state_next == HOLD));

      // Capture on the last enable cycle, while the LCD is still driving.
      if (w_sample) begin
        if (BUS_MODE == 4) begin
          if (r_nibble) r_rd_buf[3:0] <= LCD_data[7:4];
          else          r_rd_buf[7:4] <= LCD_data[7:4];
        end else begin
          r_rd_buf <= LCD_data;
        end
      end

      if (w_renib) begin
        r_nibble <= 1'b1;
      end else if (r_state == DONE) begin
        r_nibble <= 1'b0;
      end

      // readdata only changes on completion of a read.
      if (w_done_entry && r_op_rd) begin
        readdata <= r_rd_buf;
      end
    end
  end

  generate
    if (BUS_MODE == 4) begin : g_bus4
      logic w_unused_lo;
      assign w_unused_lo   = &{1'b0, LCD_data[3:0]};
      assign LCD_data[7:4] = r_data_oe ? (r_nibble ? r_wdata[3:0] : r_wdata[7:4]) : 4'bz;
      assign LCD_data[3:0] = 4'bz;
    end else begin : g_bus8
      assign LCD_data = r_data_oe ? r_wdata : 8'bz;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lcd_timed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timed_ctrl
// Brief    : Directed bench for lcd_timed_ctrl in 8-bit and 4-bit modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timed_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       rd8, wr8, rd4, wr4;
  logic [7:0] rdata8, rdata4;
  logic       wait8, wait4;
  logic       e8, rs8, rw8, e4, rs4, rw4;
  wire  [7:0] lcd8;
  wire  [7:0] lcd4;

  logic       drv8_en;
  logic [7:0] drv8_val;
  logic       drv4_en;
  logic [3:0] drv4_val;

  // Bench-side LCD model: drives read data only while requested.
  assign lcd8      = drv8_en ? drv8_val : 8'bz;
  assign lcd4[7:4] = drv4_en ? drv4_val : 4'bz;

  lcd_timed_ctrl #(.BUS_MODE(8)) u_dut8 (
    .clk(clk), .reset(reset), .address(address), .read(rd8), .write(wr8),
    .writedata(writedata), .readdata(rdata8), .waitrequest(wait8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(lcd8)
  );

  lcd_timed_ctrl #(.BUS_MODE(4)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .read(rd4), .write(wr4),
    .writedata(writedata), .readdata(rdata4), .waitrequest(wait4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(lcd4)
  );

  int cyc = 0;
  // Free-running cycle stamp for measuring E spacing.
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one access starting in the current cycle (called #1 after posedge).
  // match_a counts cycles the bus shows wd (8-bit) or wd[7:4] (4-bit);
  // match_b counts cycles the 4-bit bus shows wd[3:0].
  task automatic run_access(input bit m4, input bit is_rd, input logic [1:0] addr,
                            input logic [7:0] wd, input logic [7:0] rv, input bit keep,
                            output int lat, output int e_hi, output int pulses,
                            output int match_a, output int match_b,
                            output logic rs_e, output logic rw_e,
                            output logic [7:0] rdone, output int rise_abs);
    logic e, prev_e, wt;
    address   = addr;
    writedata = wd;
    if (m4) begin rd4 = is_rd; wr4 = !is_rd; end
    else    begin rd8 = is_rd; wr8 = !is_rd; end
    lat = -1; e_hi = 0; pulses = 0; match_a = 0; match_b = 0;
    rs_e = 1'b0; rw_e = 1'b0; rdone = 8'h00; rise_abs = -1;
    prev_e = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      e  = m4 ? e4 : e8;
      wt = m4 ? wait4 : wait8;
      if (m4) begin
        if (lcd4[7:4] === wd[7:4]) match_a++;
        if (lcd4[7:4] === wd[3:0]) match_b++;
      end else begin
        if (lcd8 === wd) match_a++;
      end
      if (e) begin
        e_hi++;
        if (!prev_e) begin
          pulses++;
          if (pulses == 1) begin
            rs_e     = m4 ? rs4 : rs8;
            rw_e     = m4 ? rw4 : rw8;
            rise_abs = cyc;
          end
          if (is_rd) begin
            if (m4) begin drv4_val = (pulses == 1) ? rv[7:4] : rv[3:0]; drv4_en = 1'b1; end
            else    begin drv8_val = rv; drv8_en = 1'b1; end
          end
        end
      end else begin
        drv4_en = 1'b0;
        drv8_en = 1'b0;
      end
      prev_e = e;
      if (!wt) begin
        lat   = c;
        rdone = m4 ? rdata4 : rdata8;
        break;
      end
    end
    @(posedge clk);
    #1;
    drv4_en = 1'b0;
    drv8_en = 1'b0;
    if (!keep) begin rd4 = 1'b0; wr4 = 1'b0; rd8 = 1'b0; wr8 = 1'b0; end
  endtask

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    int lat, e_hi, pulses, ma, mb, rise1, rise2;
    logic rs_e, rw_e;
    logic [7:0] rdone;

    reset = 1'b1; address = 2'b00; writedata = 8'h00;
    rd8 = 1'b0; wr8 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
    drv8_en = 1'b0; drv8_val = 8'h00; drv4_en = 1'b0; drv4_val = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_e8",    {31'd0, e8},   32'd0);
    check("rst_rs8",   {31'd0, rs8},  32'd0);
    check("rst_rw8",   {31'd0, rw8},  32'd0);
    check("rst_rd8",   {24'd0, rdata8}, 32'h00);
    check("rst_wait8", {31'd0, wait8}, 32'd0);
    check("rst_e4",    {31'd0, e4},   32'd0);
    check("rst_rd4",   {24'd0, rdata4}, 32'h00);

    // 8-bit status read: LCD returns 0x80.
    run_access(1'b0, 1'b1, 2'b01, 8'h5A, 8'h80, 1'b0, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise1);
    check("r8_lat",    lat, 32'd56);
    check("r8_ehi",    e_hi, 32'd25);
    check("r8_pulses", pulses, 32'd1);
    check("r8_rs",     {31'd0, rs_e}, 32'd0);
    check("r8_rw",     {31'd0, rw_e}, 32'd1);
    check("r8_nodrv",  ma, 32'd0);
    check("r8_data",   {24'd0, rdone}, 32'h80);

    // 8-bit instruction write 0x38.
    run_access(1'b0, 1'b0, 2'b00, 8'h38, 8'h00, 1'b0, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise1);
    check("w8_lat",    lat, 32'd56);
    check("w8_ehi",    e_hi, 32'd25);
    check("w8_datcyc", ma, 32'd30);
    check("w8_rs",     {31'd0, rs_e}, 32'd0);
    check("w8_rw",     {31'd0, rw_e}, 32'd0);
    check("w8_rdhold", {24'd0, rdata8}, 32'h80);

    // 4-bit data write 0x28: nibble 2 then 8.
    run_access(1'b1, 1'b0, 2'b10, 8'h28, 8'h00, 1'b0, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise1);
    check("w4_lat",    lat, 32'd111);
    check("w4_ehi",    e_hi, 32'd50);
    check("w4_pulses", pulses, 32'd2);
    check("w4_nib_hi", ma, 32'd30);
    check("w4_nib_lo", mb, 32'd30);
    check("w4_rs",     {31'd0, rs_e}, 32'd1);
    check("w4_rw",     {31'd0, rw_e}, 32'd0);

    // 4-bit data read: LCD returns A then 5.
    run_access(1'b1, 1'b1, 2'b11, 8'h33, 8'hA5, 1'b0, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise1);
    check("r4_lat",    lat, 32'd111);
    check("r4_pulses", pulses, 32'd2);
    check("r4_nodrv",  ma, 32'd0);
    check("r4_rw",     {31'd0, rw_e}, 32'd1);
    check("r4_data",   {24'd0, rdone}, 32'hA5);

    // Back-to-back 8-bit writes with the request held throughout.
    run_access(1'b0, 1'b0, 2'b00, 8'h01, 8'h00, 1'b1, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise1);
    check("bb1_lat",   lat, 32'd56);
    check("bb1_dat",   ma, 32'd30);
    run_access(1'b0, 1'b0, 2'b00, 8'h0C, 8'h00, 1'b0, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise2);
    check("bb2_lat",   lat, 32'd56);
    check("bb2_dat",   ma, 32'd30);
    check("bb_egap",   rise2 - rise1, 32'd57);

    // Reset during the 10th enable cycle of a held data write.
    address = 2'b10; writedata = 8'h38; wr8 = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    check("rst_mid_e_pre",  {31'd0, e8},  32'd1);
    check("rst_mid_rs_pre", {31'd0, rs8}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_e",   {31'd0, e8},  32'd0);
    check("rst_mid_rs",  {31'd0, rs8}, 32'd0);
    check("rst_mid_rw",  {31'd0, rw8}, 32'd0);
    check("rst_mid_rd",  {24'd0, rdata8}, 32'h00);
    check("rst_mid_bus", {31'd0, (lcd8 === 8'h38)}, 32'd0);
    run_access(1'b0, 1'b0, 2'b10, 8'h38, 8'h00, 1'b0, lat, e_hi, pulses, ma, mb, rs_e, rw_e, rdone, rise1);
    check("rst_re_lat",  lat, 32'd56);
    check("rst_re_ehi",  e_hi, 32'd25);
    check("rst_re_dat",  ma, 32'd30);
    check("rst_re_rs",   {31'd0, rs_e}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
